spi_slave_regs: RTL and testbench

SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

---
 rtl/spi_slave_regs.sv | 192 +++++++++++++++++++
 tb/tb_spi_slave_regs.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave giving a host read/write access to a small register file.
// All SPI pins are oversampled in the master_clk domain; a frame is one R/W
// bit (1 = read), ADDR_W address bits, then DATA_W data bits, MSB first.
module spi_slave_regs #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4
) (
  input  logic                         master_clk,
  input  logic                         rst_n,
  input  logic                         spi_cs_n,
  input  logic                         spi_sclk,
  input  logic                         spi_mosi,
  output logic                         spi_miso,
  output logic                         spi_miso_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_stb,
  output logic [ADDR_W-1:0]            wr_addr
);

  localparam int MAXB  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAXB + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_WAIT_CS} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_cs_s1, r_cs_s2, r_cs_d;
  logic                r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic                r_mosi_s1, r_mosi_s2;
  logic [1:0]          r_warm;
  logic                r_armed;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_hdr;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_miso_sr;
  logic                r_wr_pend;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic                w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
  logic                w_hdr_done, w_data_done;
  logic [ADDR_W:0]     w_hdr;
  logic [DATA_W-1:0]   w_rd_val;
  logic                w_wr_hit;

  // Two-flop synchronisers plus one delay flop for edge detection. A frame
  // may only start once cs_n has been seen high after reset, so a host that
  // held cs_n low across reset must deassert it before a frame is decoded.
  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_d    <= 1'b1;
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_warm    <= 2'b00;
      r_armed   <= 1'b0;
    end else begin
      r_cs_s1   <= spi_cs_n;
      r_cs_s2   <= r_cs_s1;
      r_cs_d    <= r_cs_s2;
      r_sclk_s1 <= spi_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_mosi_s1 <= spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_warm    <= {r_warm[0], 1'b1};
      r_armed   <= r_armed | (r_warm[1] & r_cs_s2);
    end
  end

  assign w_cs_fall   = r_armed & r_cs_d & ~r_cs_s2;
  assign w_cs_rise   = ~r_cs_d & r_cs_s2;
  assign w_sclk_rise = ~r_sclk_d & r_sclk_s2;
  assign w_sclk_fall = r_sclk_d & ~r_sclk_s2;
  assign w_hdr       = {r_hdr, r_mosi_s2};

  // State register.
  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; a cs_n rising edge always wins and aborts the frame.
  always_comb begin
    w_state_nxt = r_state;
    w_hdr_done  = 1'b0;
    w_data_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (w_cs_rise) begin
          w_state_nxt = S_IDLE;
        end else if (w_sclk_rise && (r_cnt == CNT_W'(ADDR_W))) begin
          w_hdr_done  = 1'b1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_cs_rise) begin
          w_state_nxt = S_IDLE;
        end else if (w_sclk_rise && (r_cnt == CNT_W'(DATA_W - 1))) begin
          w_data_done = 1'b1;
          w_state_nxt = S_WAIT_CS;
        end
      end
      S_WAIT_CS: begin
        if (w_cs_rise) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Register-file read mux (out-of-range reads give 0) and write address decode.
  always_comb begin
    w_rd_val = '0;
    w_wr_hit = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_hdr[ADDR_W-1:0] == ADDR_W'(k)) w_rd_val = r_regs[k];
      if (r_addr == ADDR_W'(k))            w_wr_hit = 1'b1;
    end
  end

  // Frame datapath: bit counter, header/data shift registers, miso shifter.
  // The miso MSB is loaded on the last header rising edge, so the falling
  // edge before the first data bit must not shift (counter still zero).
  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_hdr     <= '0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_miso_sr <= '0;
      r_wr_pend <= 1'b0;
    end else begin
      r_wr_pend <= 1'b0;
      if (r_state == S_IDLE && w_cs_fall) begin
        r_cnt <= '0;
      end else if (r_state == S_ADDR && w_sclk_rise) begin
        r_hdr <= w_hdr[ADDR_W-1:0];
        r_cnt <= w_hdr_done ? '0 : r_cnt + CNT_W'(1);
      end else if (r_state == S_DATA && w_sclk_rise) begin
        r_wdata <= {r_wdata[DATA_W-2:0], r_mosi_s2};
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      if (w_hdr_done) begin
        r_rw      <= w_hdr[ADDR_W];
        r_addr    <= w_hdr[ADDR_W-1:0];
        r_miso_sr <= w_hdr[ADDR_W] ? w_rd_val : '0;
      end else if (r_state == S_DATA && w_sclk_fall && r_cnt != '0) begin
        r_miso_sr <= {r_miso_sr[DATA_W-2:0], 1'b0};
      end
      if (w_data_done) r_wr_pend <= ~r_rw & w_wr_hit;
    end
  end

  // Register file update and write strobe, one cycle after the frame completes.
  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (r_wr_pend) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (r_addr == ADDR_W'(k)) r_regs[k] <= r_wdata;
        end
        wr_stb  <= 1'b1;
        wr_addr <= r_addr;
      end
    end
  end

  // Flatten the register file onto the output bus.
  always_comb begin
    regs_flat = '0;
    for (int k = 0; k < NUM_REGS; k++) regs_flat[k*DATA_W +: DATA_W] = r_regs[k];
  end

  assign spi_miso    = (r_state == S_DATA) ? r_miso_sr[DATA_W-1] : 1'b0;
  assign spi_miso_oe = ~r_cs_s2;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: directed vector table, mid-frame reset sequence,
// then random frames checked against a register-array model.
module tb_spi_slave_regs;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;
  localparam int HALF     = 8;

  logic        master_clk = 1'b0;
  logic        rst_n      = 1'b0;
  logic        spi_cs_n   = 1'b1;
  logic        spi_sclk   = 1'b0;
  logic        spi_mosi   = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [31:0] regs_flat;
  logic        wr_stb;
  logic [6:0]  wr_addr;

  int          total = 0;
  int          bad   = 0;
  int          stb_cnt = 0;
  logic [6:0]  last_wa = '0;
  logic [7:0]  model [NUM_REGS];

  typedef struct {
    bit         rw;
    logic [6:0] addr;
    logic [7:0] data;
    int         nbits;
    int         extra;
    logic [7:0] exp_rd;
    int         exp_stb;
  } vec_t;

  vec_t vecs [11];

  spi_slave_regs #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .master_clk (master_clk),
    .rst_n      (rst_n),
    .spi_cs_n   (spi_cs_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .regs_flat  (regs_flat),
    .wr_stb     (wr_stb),
    .wr_addr    (wr_addr)
  );

  always #5 master_clk = ~master_clk;

  always @(negedge master_clk) begin
    if (wr_stb === 1'b1) begin
      stb_cnt = stb_cnt + 1;
      last_wa = wr_addr;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge master_clk);
  endtask

  function automatic logic [31:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NUM_REGS; k++) model[k] = 8'h00;
  endtask

  // Architectural effect of a frame: complete in-range writes update the
  // register; reads see the current contents, or zero when out of range.
  task automatic model_apply(input bit rw, input logic [6:0] addr, input logic [7:0] data,
                             input int nbits, output logic [7:0] rd, output int stbs);
    rd   = 8'h00;
    stbs = 0;
    if (rw) begin
      if (int'(addr) < NUM_REGS) rd = model[addr];
    end else if (nbits == 8 && int'(addr) < NUM_REGS) begin
      model[addr] = data;
      stbs = 1;
    end
  endtask

  task automatic send_bit(input logic b, output logic smp);
    spi_mosi = b;
    wait_clk(HALF);
    spi_sclk = 1'b1;
    smp = spi_miso;
    wait_clk(HALF);
    spi_sclk = 1'b0;
  endtask

  task automatic run_frame(input bit rw, input logic [6:0] addr, input logic [7:0] data,
                           input int nbits, input int extra,
                           output logic [7:0] rd, output int stbs, output logic [6:0] wa);
    logic [7:0] hdr;
    logic       smp;
    int         s0;
    s0  = stb_cnt;
    hdr = {rw, addr};
    rd  = 8'h00;
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 8; i++) begin
      send_bit(hdr[7-i], smp);
      if (i == 3) begin
        chk("miso_addr", 32'(spi_miso), 32'd0);
        chk("oe_frame", 32'(spi_miso_oe), 32'd1);
      end
    end
    for (int j = 0; j < nbits; j++) begin
      send_bit(data[7-j], smp);
      rd[7-j] = smp;
    end
    for (int e = 0; e < extra; e++) send_bit(1'b1, smp);
    wait_clk(HALF);
    if (nbits == 8) chk("miso_wait", 32'(spi_miso), 32'd0);
    spi_cs_n = 1'b1;
    wait_clk(2*HALF + 4);
    chk("oe_idle", 32'(spi_miso_oe), 32'd0);
    stbs = stb_cnt - s0;
    wa   = last_wa;
  endtask

  initial begin
    logic [7:0] rd, m_rd, smp;
    logic [6:0] wa;
    int         stbs, m_stb;
    logic       b;
    logic [15:0] junk;

    vecs[0]  = '{1'b0, 7'h02, 8'hA5, 8, 0,  8'h00, 1};
    vecs[1]  = '{1'b1, 7'h02, 8'h00, 8, 0,  8'hA5, 0};
    vecs[2]  = '{1'b0, 7'h05, 8'hFF, 8, 0,  8'h00, 0};
    vecs[3]  = '{1'b1, 7'h05, 8'h00, 8, 0,  8'h00, 0};
    vecs[4]  = '{1'b0, 7'h01, 8'h5A, 4, 0,  8'h00, 0};
    vecs[5]  = '{1'b1, 7'h01, 8'h00, 8, 0,  8'h00, 0};
    vecs[6]  = '{1'b0, 7'h01, 8'hC3, 8, 0,  8'h00, 1};
    vecs[7]  = '{1'b1, 7'h01, 8'h00, 8, 0,  8'hC3, 0};
    vecs[8]  = '{1'b0, 7'h00, 8'h3C, 8, 12, 8'h00, 1};
    vecs[9]  = '{1'b1, 7'h00, 8'h00, 8, 0,  8'h3C, 0};
    vecs[10] = '{1'b1, 7'h03, 8'h00, 8, 0,  8'h00, 0};

    // Reset state.
    model_clear();
    wait_clk(4);
    chk("rst_regs", regs_flat, 32'd0);
    chk("rst_miso", 32'(spi_miso), 32'd0);
    chk("rst_oe", 32'(spi_miso_oe), 32'd0);
    chk("rst_stb", 32'(wr_stb), 32'd0);
    chk("rst_waddr", 32'(wr_addr), 32'd0);
    rst_n = 1'b1;
    wait_clk(6);

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      run_frame(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].nbits, vecs[i].extra, rd, stbs, wa);
      model_apply(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].nbits, m_rd, m_stb);
      if (vecs[i].rw) chk($sformatf("vec%0d_rd", i), 32'(rd), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_stb", i), 32'(stbs), 32'(vecs[i].exp_stb));
      if (vecs[i].exp_stb == 1) chk($sformatf("vec%0d_waddr", i), 32'(wa), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_regs", i), regs_flat, model_flat());
    end

    // Reset asserted mid-frame with registers populated, cs_n held low across it.
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 5; i++) send_bit(1'b0, b);
    rst_n = 1'b0;
    model_clear();
    wait_clk(3);
    chk("mrst_regs", regs_flat, 32'd0);
    chk("mrst_miso", 32'(spi_miso), 32'd0);
    chk("mrst_oe", 32'(spi_miso_oe), 32'd0);
    chk("mrst_stb", 32'(wr_stb), 32'd0);
    chk("mrst_waddr", 32'(wr_addr), 32'd0);
    rst_n = 1'b1;
    wait_clk(4);
    stbs = stb_cnt;
    junk = {1'b0, 7'h00, 8'hFF};
    for (int i = 0; i < 16; i++) send_bit(junk[15-i], b);
    wait_clk(2*HALF);
    chk("nocs_stb", 32'(stb_cnt - stbs), 32'd0);
    chk("nocs_regs", regs_flat, 32'd0);
    spi_cs_n = 1'b1;
    wait_clk(2*HALF);
    run_frame(1'b0, 7'h03, 8'h77, 8, 0, rd, stbs, wa);
    model_apply(1'b0, 7'h03, 8'h77, 8, m_rd, m_stb);
    chk("post_rst_stb", 32'(stbs), 32'd1);
    chk("post_rst_waddr", 32'(wa), 32'h03);
    chk("post_rst_regs", regs_flat, model_flat());
    run_frame(1'b1, 7'h03, 8'h00, 8, 0, rd, stbs, wa);
    chk("post_rst_rd", 32'(rd), 32'h77);

    // Random frames against the model.
    for (int n = 0; n < 30; n++) begin
      bit         rw;
      logic [6:0] addr;
      logic [7:0] data;
      int         nbits, extra;
      rw    = 1'($urandom_range(0, 1));
      addr  = 7'($urandom_range(0, 7));
      data  = 8'($urandom);
      nbits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : 8;
      extra = (nbits == 8) ? int'($urandom_range(0, 3)) : 0;
      run_frame(rw, addr, data, nbits, extra, rd, stbs, wa);
      model_apply(rw, addr, data, nbits, m_rd, m_stb);
      if (rw && nbits == 8) chk($sformatf("rnd%0d_rd", n), 32'(rd), 32'(m_rd));
      chk($sformatf("rnd%0d_stb", n), 32'(stbs), 32'(m_stb));
      if (m_stb == 1) chk($sformatf("rnd%0d_waddr", n), 32'(wa), 32'(addr));
      chk($sformatf("rnd%0d_regs", n), regs_flat, model_flat());
    end

    smp = 8'h00;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
